// File: rtl/usb_timer_pkg.sv
// Shared timer types and default bit-timing constants for the USB receive bit timer.
package usb_timer_pkg;

  typedef enum logic {
    StIdle,
    StRun
  } timer_state_e;

  localparam int unsigned DefClksPerBit  = 8;
  localparam int unsigned DefSamplePoint = 3;
  localparam int unsigned DefBitsPerByte = 8;

endpackage

// File: rtl/flex_counter.sv
// Rollover counter: counts 1..rollover_val, holds 0 when cleared.
module flex_counter #(
  parameter int unsigned SIZE = 4
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            clear,
  input  logic            count_enable,
  input  logic [SIZE-1:0] rollover_val,
  output logic [SIZE-1:0] count_out
);

  localparam logic [SIZE-1:0] One = {{(SIZE-1){1'b0}}, 1'b1};

  logic [SIZE-1:0] count_q, count_d;

  // A clear that coincides with an enable restarts the count at 1 (that cycle is the first counted).
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = count_enable ? One : '0;
    end else if (count_enable) begin
      count_d = (count_q == rollover_val) ? One : count_q + One;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;

endmodule

// File: rtl/usb_bit_timer.sv
// USB receive bit timer: generates bit-sample strobes and end-of-byte pulses, with
// phase resync on line transitions.
module usb_bit_timer #(
  parameter int unsigned CLKS_PER_BIT  = usb_timer_pkg::DefClksPerBit,
  parameter int unsigned SAMPLE_POINT  = usb_timer_pkg::DefSamplePoint,
  parameter int unsigned BITS_PER_BYTE = usb_timer_pkg::DefBitsPerByte
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       enable_timer,
  input  logic       clear,
  input  logic       d_edge,
  output logic       shift_strobe,
  output logic       byte_received,
  output logic [3:0] bit_count
);

  import usb_timer_pkg::*;

  localparam logic [3:0] ClkRollover = 4'(CLKS_PER_BIT);
  localparam logic [3:0] SampleCnt   = 4'(SAMPLE_POINT);
  localparam logic [3:0] ByteLen     = 4'(BITS_PER_BYTE);

  timer_state_e state_q, state_d;
  logic [3:0]   clk_cnt;
  logic         run, run_next;
  logic         clk_clear, bit_clear, bit_enable;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (enable_timer && !clear) state_d = StRun;
      StRun:  if (!enable_timer || clear) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign run      = (state_q == StRun);
  assign run_next = (state_d == StRun);

  assign shift_strobe  = run && (clk_cnt == SampleCnt);
  assign byte_received = run && (bit_count == ByteLen);

  // Entering RUN or resyncing restarts the clock count at 1; leaving RUN parks it at 0.
  assign clk_clear = !run_next || (run && d_edge);

  // A strobe on the cycle we drop out of RUN must not survive into IDLE.
  assign bit_enable = shift_strobe && run_next;
  assign bit_clear  = !run_next || byte_received;

  flex_counter #(
    .SIZE(4)
  ) u_clk_counter (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (clk_clear),
    .count_enable(run_next),
    .rollover_val(ClkRollover),
    .count_out   (clk_cnt)
  );

  flex_counter #(
    .SIZE(4)
  ) u_bit_counter (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (bit_clear),
    .count_enable(bit_enable),
    .rollover_val(ByteLen),
    .count_out   (bit_count)
  );

endmodule

// File: tb/tb_usb_bit_timer.sv
// Directed bench for usb_bit_timer: default timing, resync, abort, clear, reset and a
// maximum-parameter instance.
module tb_usb_bit_timer;

  logic tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  logic       n_rst, enable_timer, clear, d_edge;
  logic       shift_strobe, byte_received;
  logic [3:0] bit_count;
  logic       en_max, strobe_max, byte_max;
  logic [3:0] count_max;

  int n_checks = 0;
  int n_fails  = 0;

  usb_bit_timer dut (
    .clk          (tb_clk),
    .n_rst        (n_rst),
    .enable_timer (enable_timer),
    .clear        (clear),
    .d_edge       (d_edge),
    .shift_strobe (shift_strobe),
    .byte_received(byte_received),
    .bit_count    (bit_count)
  );

  usb_bit_timer #(
    .CLKS_PER_BIT (15),
    .SAMPLE_POINT (15),
    .BITS_PER_BYTE(15)
  ) dut_max (
    .clk          (tb_clk),
    .n_rst        (n_rst),
    .enable_timer (en_max),
    .clear        (1'b0),
    .d_edge       (1'b0),
    .shift_strobe (strobe_max),
    .byte_received(byte_max),
    .bit_count    (count_max)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fails++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int s, input int b, input int c);
    check({tag, "/strobe"}, int'(shift_strobe), s);
    check({tag, "/byte"}, int'(byte_received), b);
    check({tag, "/count"}, int'(bit_count), c);
  endtask

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  initial begin
    n_rst = 1'b0; enable_timer = 1'b0; clear = 1'b0; d_edge = 1'b0; en_max = 1'b0;
    #2;
    check_outs("reset", 0, 0, 0);
    check("reset_max/count", int'(count_max), 0);
    #20;
    n_rst = 1'b1;
    tick();
    check_outs("idle", 0, 0, 0);

    // d_edge while idle has no effect
    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
    check_outs("idle_dedge", 0, 0, 0);

    // Default run: strobes at 3,11,..,59, byte at 60
    enable_timer = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      tick();
      check_outs($sformatf("run%0d", k),
                 (k >= 3 && k <= 59 && (k - 3) % 8 == 0) ? 1 : 0,
                 (k == 60) ? 1 : 0,
                 (k > 60) ? 0 : (k + 4) / 8);
    end
    enable_timer = 1'b0;
    tick();
    check_outs("run_stop", 0, 0, 0);

    // Resync: d_edge in cycle 6 moves the next strobe to cycle 9
    enable_timer = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      check_outs($sformatf("resync%0d", k),
                 (k == 3 || k == 9 || k == 17) ? 1 : 0, 0,
                 (k <= 3) ? 0 : ((k <= 9) ? 1 : 2));
      d_edge = (k == 6);
    end
    enable_timer = 1'b0;
    tick();
    check_outs("resync_stop", 0, 0, 0);

    // Abort after the 5th strobe (cycle 35)
    enable_timer = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      tick();
      check_outs($sformatf("abort%0d", k),
                 (k >= 3 && (k - 3) % 8 == 0) ? 1 : 0, 0, (k + 4) / 8);
    end
    enable_timer = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check_outs($sformatf("abort_idle%0d", k), 0, 0, 0);
    end
    enable_timer = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      check_outs($sformatf("restart%0d", k),
                 (k == 3 || k == 11) ? 1 : 0, 0, (k >= 4) ? 1 : 0);
    end

    // Clear with enable and d_edge during a strobe cycle
    clear = 1'b1;
    d_edge = 1'b1;
    tick();
    check_outs("clear", 0, 0, 0);
    d_edge = 1'b0;
    tick();
    check_outs("clear_hold", 0, 0, 0);
    clear = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      check_outs($sformatf("clear_rerun%0d", k),
                 (k == 3 || k == 11) ? 1 : 0, 0, (k >= 4) ? 1 : 0);
    end

    // Asynchronous reset mid-run while a strobe is high
    #3;
    n_rst = 1'b0;
    #1;
    check_outs("async_reset", 0, 0, 0);
    #2;
    n_rst = 1'b1;
    #1;
    check_outs("post_release", 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_outs($sformatf("post_reset%0d", k), (k == 3) ? 1 : 0, 0, (k == 4) ? 1 : 0);
    end
    enable_timer = 1'b0;
    tick();
    check_outs("post_reset_stop", 0, 0, 0);

    // Maximum parameters: strobes every 15 cycles, 15 bits per byte
    en_max = 1'b1;
    for (int k = 1; k <= 230; k++) begin
      tick();
      check($sformatf("max%0d/strobe", k), int'(strobe_max),
            (k % 15 == 0 && k <= 225) ? 1 : 0);
      check($sformatf("max%0d/byte", k), int'(byte_max), (k == 226) ? 1 : 0);
      check($sformatf("max%0d/count", k), int'(count_max),
            (k <= 225) ? (k - 1) / 15 : ((k == 226) ? 15 : 0));
    end
    en_max = 1'b0;
    tick();
    check("max_stop/count", int'(count_max), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
